led_mode_sched: RTL and testbench



---
 rtl/led_mode_sched_if.sv | 28 ++
 rtl/led_mode_sched.sv | 103 ++++++++++
 tb/tb_led_mode_sched.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/led_mode_sched_if.sv
// Key-to-LED scheduler bundle: debounced key pulses in,
// registered LED pattern and status out.
interface led_mode_sched_if;
  logic       key_mode;
  logic       key_pause;
  logic [3:0] led;
  logic [1:0] mode;
  logic       paused;
  logic       step_tick;

  modport master (
    output key_mode,
    output key_pause,
    input  led,
    input  mode,
    input  paused,
    input  step_tick
  );

  modport slave (
    input  key_mode,
    input  key_pause,
    output led,
    output mode,
    output paused,
    output step_tick
  );
endinterface

// File: rtl/led_mode_sched.sv
// LED bank pattern scheduler: four display modes paced by a
// shared step timer, driven by mode/pause key pulses.
module led_mode_sched #(
  parameter int unsigned TIME_STEP = 25_000_000,
  parameter int unsigned CNT_W     = 25
) (
  input logic              clk,
  input logic              rst_n,
  led_mode_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_FLOW  = 2'd1,
    M_BLINK = 2'd2,
    M_ALTER = 2'd3
  } mode_t;

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIME_STEP - 1);

  mode_t            st, st_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       led_q, led_nx;
  logic             pau, pau_nx;
  logic             tick, tick_nx;
  logic             run;
  logic             term;

  function automatic logic [3:0] entry_pat(mode_t m);
    logic [3:0] p;
    unique case (m)
      M_OFF:   p = 4'b0000;
      M_FLOW:  p = 4'b0001;
      M_BLINK: p = 4'b1111;
      M_ALTER: p = 4'b0101;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] next_pat(mode_t m,
                                          logic [3:0] l);
    logic [3:0] p;
    unique case (m)
      M_OFF:   p = l;
      M_FLOW:  p = {l[2:0], l[3]};
      M_BLINK: p = ~l;
      M_ALTER: p = ~l;
    endcase
    return p;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= M_OFF;
      cnt   <= '0;
      led_q <= 4'b0000;
      pau   <= 1'b0;
      tick  <= 1'b0;
    end else begin
      st    <= st_nx;
      cnt   <= cnt_nx;
      led_q <= led_nx;
      pau   <= pau_nx;
      tick  <= tick_nx;
    end
  end

  assign run  = (st != M_OFF) && !pau;
  assign term = (cnt == TERM);

  // Mode key wins over both pause and the terminal step.
  always_comb begin
    st_nx   = st;
    cnt_nx  = cnt;
    led_nx  = led_q;
    pau_nx  = pau;
    tick_nx = 1'b0;
    if (bus.key_mode) begin
      st_nx  = mode_t'(st + 2'd1);
      led_nx = entry_pat(st_nx);
      cnt_nx = '0;
      pau_nx = 1'b0;
    end else begin
      if (run) begin
        if (term) begin
          cnt_nx  = '0;
          tick_nx = 1'b1;
          led_nx  = next_pat(st, led_q);
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      if (bus.key_pause && (st != M_OFF))
        pau_nx = ~pau;
    end
  end

  assign bus.led       = led_q;
  assign bus.mode      = st;
  assign bus.paused    = pau;
  assign bus.step_tick = tick;

endmodule

// File: tb/tb_led_mode_sched.sv
// Bench for led_mode_sched: vector table, directed corners,
// and random keys against an elapsed-time reference model.
module tb_led_mode_sched;

  localparam int TS = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  led_mode_sched_if bus ();

  led_mode_sched #(
    .TIME_STEP (TS),
    .CNT_W     (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: mode, pause flag, and running cycles since mode entry.
  int m_mode = 0;
  int m_el   = 0;
  bit m_p    = 0;
  bit m_tick = 0;

  function automatic logic [3:0] m_led();
    int k;
    logic [3:0] r;
    k = m_el / TS;
    case (m_mode)
      1:       r = 4'(4'b0001 << (k % 4));
      2:       r = (k % 2) ? 4'b0000 : 4'b1111;
      3:       r = (k % 2) ? 4'b1010 : 4'b0101;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  function automatic void m_reset();
    m_mode = 0;
    m_el   = 0;
    m_p    = 0;
    m_tick = 0;
  endfunction

  function automatic void m_step(bit km, bit kp);
    m_tick = 0;
    if (km) begin
      m_mode = (m_mode + 1) % 4;
      m_el   = 0;
      m_p    = 0;
    end else begin
      if (m_mode != 0 && !m_p) begin
        m_el++;
        m_tick = (m_el % TS == 0);
      end
      if (kp && m_mode != 0) m_p = !m_p;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("led", 32'(bus.led), 32'(m_led()));
    chk("mode", 32'(bus.mode), 32'(m_mode));
    chk("paused", 32'(bus.paused), 32'(m_p));
    chk("tick", 32'(bus.step_tick), 32'(m_tick));
  endtask

  task automatic cyc(input bit km, input bit kp);
    bus.key_mode  = km;
    bus.key_pause = kp;
    @(posedge clk);
    m_step(km, kp);
    #1;
    bus.key_mode  = 1'b0;
    bus.key_pause = 1'b0;
    cmp_model();
  endtask

  typedef struct {
    bit         km;
    bit         kp;
    int         idle;
    logic [3:0] led;
    logic [1:0] mode;
    bit         paused;
    bit         tick;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bus.key_mode  = 1'b0;
    bus.key_pause = 1'b0;

    // flow steps
    tbl.push_back('{1, 0, 0,  4'b0001, 2'd1, 0, 0});
    tbl.push_back('{0, 0, 9,  4'b0010, 2'd1, 0, 1});
    tbl.push_back('{0, 0, 9,  4'b0100, 2'd1, 0, 1});
    tbl.push_back('{0, 0, 9,  4'b1000, 2'd1, 0, 1});
    tbl.push_back('{0, 0, 9,  4'b0001, 2'd1, 0, 1});
    tbl.push_back('{0, 0, 4,  4'b0001, 2'd1, 0, 0});
    // blink, alter, back to off
    tbl.push_back('{1, 0, 0,  4'b1111, 2'd2, 0, 0});
    tbl.push_back('{0, 0, 9,  4'b0000, 2'd2, 0, 1});
    tbl.push_back('{1, 0, 0,  4'b0101, 2'd3, 0, 0});
    tbl.push_back('{0, 0, 9,  4'b1010, 2'd3, 0, 1});
    tbl.push_back('{1, 0, 0,  4'b0000, 2'd0, 0, 0});
    tbl.push_back('{0, 0, 50, 4'b0000, 2'd0, 0, 0});
    // pause hold and resume from held count
    tbl.push_back('{1, 0, 0,  4'b0001, 2'd1, 0, 0});
    tbl.push_back('{0, 1, 0,  4'b0001, 2'd1, 1, 0});
    tbl.push_back('{0, 0, 99, 4'b0001, 2'd1, 1, 0});
    tbl.push_back('{0, 1, 0,  4'b0001, 2'd1, 0, 0});
    tbl.push_back('{0, 0, 7,  4'b0001, 2'd1, 0, 0});
    tbl.push_back('{0, 0, 0,  4'b0010, 2'd1, 0, 1});
    // pause ignored in off
    tbl.push_back('{1, 0, 0,  4'b1111, 2'd2, 0, 0});
    tbl.push_back('{1, 0, 0,  4'b0101, 2'd3, 0, 0});
    tbl.push_back('{1, 0, 0,  4'b0000, 2'd0, 0, 0});
    tbl.push_back('{0, 1, 0,  4'b0000, 2'd0, 0, 0});
    // both keys, then mode key on terminal count
    tbl.push_back('{1, 1, 0,  4'b0001, 2'd1, 0, 0});
    tbl.push_back('{0, 1, 0,  4'b0001, 2'd1, 1, 0});
    tbl.push_back('{1, 1, 0,  4'b1111, 2'd2, 0, 0});
    tbl.push_back('{0, 0, 8,  4'b1111, 2'd2, 0, 0});
    tbl.push_back('{1, 0, 0,  4'b0101, 2'd3, 0, 0});
    // pause on terminal count: step first, then freeze
    tbl.push_back('{0, 0, 8,  4'b0101, 2'd3, 0, 0});
    tbl.push_back('{0, 1, 0,  4'b1010, 2'd3, 1, 1});
    tbl.push_back('{0, 0, 20, 4'b1010, 2'd3, 1, 0});

    #12;
    chk("rst_led", 32'(bus.led), 32'h0);
    chk("rst_mode", 32'(bus.mode), 32'h0);
    chk("rst_paused", 32'(bus.paused), 32'h0);
    chk("rst_tick", 32'(bus.step_tick), 32'h0);
    #10;
    rst_n = 1'b1;

    repeat (100) cyc(1'b0, 1'b0);

    foreach (tbl[i]) begin
      cyc(tbl[i].km, tbl[i].kp);
      repeat (tbl[i].idle) cyc(1'b0, 1'b0);
      chk($sformatf("vec%0d_led", i), 32'(bus.led),
          32'(tbl[i].led));
      chk($sformatf("vec%0d_mode", i), 32'(bus.mode),
          32'(tbl[i].mode));
      chk($sformatf("vec%0d_paused", i), 32'(bus.paused),
          32'(tbl[i].paused));
      chk($sformatf("vec%0d_tick", i), 32'(bus.step_tick),
          32'(tbl[i].tick));
    end

    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(39) == 0, $urandom_range(14) == 0);

    // Reach ALTER showing 1010, then reset between edges.
    for (int n = 0; n < 4 && m_mode != 3; n++) cyc(1'b1, 1'b0);
    if (m_p) cyc(1'b0, 1'b1);
    for (int n = 0; n < 30 && m_led() != 4'b1010; n++)
      cyc(1'b0, 1'b0);
    chk("pre_rst_led", 32'(bus.led), 32'hA);
    chk("pre_rst_mode", 32'(bus.mode), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_led", 32'(bus.led), 32'h0);
    chk("async_mode", 32'(bus.mode), 32'h0);
    chk("async_paused", 32'(bus.paused), 32'h0);
    chk("async_tick", 32'(bus.step_tick), 32'h0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0);
    chk("post_rst_led", 32'(bus.led), 32'h1);
    chk("post_rst_mode", 32'(bus.mode), 32'h1);
    repeat (25) cyc(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
